acia_tx_cfg: RTL and testbench
==============================

# acia_tx_cfg

Configurable serial transmitter that replaces the fixed 8N1 / fixed-rate transmit path of the ACIA. It adds a runtime baud divisor, 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, and a small transmit FIFO with a valid/ready write port. The ACIA register decode drives the config inputs; `tx_serial` goes to the pad.

## Interface

Parameters:
- `DIV_W`, default 16: width of the baud divisor.
- `FIFO_DEPTH`, default 4: number of transmit FIFO entries. Must be a power of two, at least 2.
- `AW`, default log2(`FIFO_DEPTH`): FIFO address width. Derived; never overridden.

Ports (clock and reset first):
- `clk` in, 1: system clock.
- `reset_n` in, 1: asynchronous active-low reset.
- `div` in, `DIV_W`: bit period is `div`+1 clocks.
- `data_bits` in, 2: data length select; 0→5, 1→6, 2→7, 3→8 bits.
- `parity_en` in, 1: append a parity bit.
- `parity_odd` in, 1: 1 selects odd parity, 0 selects even.
- `stop2` in, 1: 1 selects two stop bits, 0 selects one.
- `tx_dat` in, 8: byte to queue. Bits above the data length are ignored.
- `tx_valid` in, 1: write request.
- `tx_ready` out, 1: FIFO not full.
- `tx_serial` out, 1: serial line, idle high.
- `tx_busy` out, 1: a frame is in progress or the FIFO is non-empty.
- `fifo_level` out, `AW`+1: number of queued entries, 0 to `FIFO_DEPTH`.

## Operation

- **Write:** a byte is accepted on any clock edge where `tx_valid` && `tx_ready`. `tx_ready` = !full, computed from registered state.
  - When the FIFO is full, a write is refused even if a pop occurs in the same cycle.
  - When not full, a simultaneous push and pop leaves `fifo_level` unchanged.
- **Shifter state machine:** IDLE → START → DATA → [PARITY] → STOP → (START or IDLE).
  - IDLE: if the FIFO is non-empty, pop the head and latch the byte, `div`, `data_bits`, `parity_en`, `parity_odd` and `stop2`. Go to START.
  - Config changes mid-frame do not affect the current frame.
  - START: `tx_serial`=0 for one bit period.
  - DATA: send bits LSB first, N bits where N = 5 + `data_bits`.
  - PARITY: present only if `parity_en`. The value is the XOR of the N data bits; invert it for odd parity.
  - STOP: `tx_serial`=1 for 1 or 2 bit periods. At the end of the last stop period:
    - FIFO non-empty → pop and go directly to START (no idle gap);
    - FIFO empty → go to IDLE.
- **Bit timer:** a down-counter loaded with `div` at every bit boundary; the bit ends on the cycle it reads 0. `div`=0 gives 1 clock per bit; the all-ones value gives 2^`DIV_W` clocks.
- **Bit counter:** counts the remaining data and stop bits. It never wraps.
- **Reset, including mid-frame:**
  - `tx_serial` goes to 1 immediately (asynchronous).
  - FIFO is flushed, state returns to IDLE.
  - `tx_busy`=0, `tx_ready`=1, `fifo_level`=0.
- `tx_serial` is driven from a flop; there is no combinational path from inputs to `tx_serial`.

## Timing

- Write accepted at edge E into an empty FIFO with the shifter idle:
  - `fifo_level`=1 after E;
  - pop at E+1 → `fifo_level`=0 and `tx_serial`=0 after E+1.
- Start-bit latency is 1 clock after acceptance.
- Frame length in clocks = (`div`+1) × (1 + N + `parity_en` + 1 + `stop2`).
- `tx_busy` rises after the accepting edge. It falls after the edge that ends the final stop bit, provided the FIFO is empty.
- With the FIFO continuously fed, frames are back-to-back: the start bit of frame k+1 begins on the edge that ends the last stop bit of frame k.

## Structure

- Shared package `acia_pkg` holds:
  - the `data_bits` encoding constants (`DB5`..`DB8`);
  - the shifter state enum (`TX_IDLE`, `TX_START`, `TX_DATA`, `TX_PARITY`, `TX_STOP`);
  - the reset level of the line (`LINE_IDLE`=1).
- One sub-module, `acia_fifo`: a synchronous FIFO parametrised by width and depth.
  - Outputs: full, empty, level.
  - Read data is valid from the head combinationally.
  - It is reused later for the receive path.
- Top level: FIFO instance plus shifter FSM, bit timer and bit counter.

## Test plan

- **8N1 single byte:** `div`=3, 8N1, write 0x55 → `tx_serial` sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 clocks. 40 clocks total; `tx_busy` falls after clock 41 from the accepting edge.
- **7E2:** `div`=1, 7 data bits, even parity, two stop bits, write 0xC3 → data bits 1,1,0,0,0,0,1, parity 1, two stop bits high. 22 clocks per frame.
- **5O1:** `div`=0, 5 data bits, odd parity, write 0xFF → 5 data bits of 1, parity 0, frame of 8 clocks.
- **FIFO fill and backpressure:** `FIFO_DEPTH`=4, `div`=7, burst-write 6 bytes holding `tx_valid` → `tx_ready` deasserts at the correct level. All bytes are sent in order, back-to-back, with no idle cycles between frames.
- **Mid-frame config change:** change `div` from 3 to 9 during the data bits of frame 1 → frame 1 keeps 4 clocks per bit, frame 2 uses 10 clocks per bit.
- **Reset mid-frame:** assert `reset_n`=0 during the parity bit with 2 bytes queued → `tx_serial`=1 and `fifo_level`=0 immediately. After release there is no further line activity until a new write.

Source files
------------

// File: rtl/acia_pkg.sv
// acia_pkg: definitions shared by the ACIA transmit and receive paths.
//   DB5..DB8    data_bits encodings (5 to 8 data bits)
//   tx_state_t  transmit shifter states
//   LINE_IDLE   level of the serial line when nothing is being sent
//   data_mask   keeps only the bits that belong to the selected data length
package acia_pkg;

  localparam logic [1:0] DB5 = 2'd0;
  localparam logic [1:0] DB6 = 2'd1;
  localparam logic [1:0] DB7 = 2'd2;
  localparam logic [1:0] DB8 = 2'd3;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  function automatic logic [7:0] data_mask(input logic [1:0] db);
    logic [7:0] m;
    case (db)
      DB5:     m = 8'h1f;
      DB6:     m = 8'h3f;
      DB7:     m = 8'h7f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/acia_tx_cfg_if.sv
// acia_tx_cfg_if: valid/ready byte write port into the transmit FIFO.
//   tx_dat    byte to queue
//   tx_valid  write request
//   tx_ready  FIFO can accept a byte this cycle
// master: the register decode side; slave: the transmitter.
interface acia_tx_cfg_if;
  logic [7:0] tx_dat;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_dat, output tx_valid, input tx_ready);
  modport slave  (input tx_dat, input tx_valid, output tx_ready);
endinterface

// File: rtl/acia_fifo.sv
// acia_fifo: synchronous FIFO shared by the ACIA transmit and receive paths.
//   clk, reset_n  clock, asynchronous active-low reset (flushes contents)
//   push, wdata   write request and data; ignored while full
//   pop           read request; ignored while empty
//   rdata         head entry, valid combinationally whenever !empty
//   full, empty   occupancy flags from registered state
//   level         number of stored entries, 0..DEPTH
// DEPTH must be a power of two (pointers wrap by overflow) and at least 2.
module acia_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  // A push while full is refused even if the same cycle pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/acia_tx_cfg.sv
// acia_tx_cfg: configurable ACIA serial transmitter.
//   clk, reset_n     clock, asynchronous active-low reset
//   div              bit period is div+1 clocks
//   data_bits        0..3 -> 5..8 data bits
//   parity_en        append parity bit; parity_odd selects odd over even
//   stop2            two stop bits instead of one
//   wr (slave)       tx_dat / tx_valid / tx_ready byte write port
//   tx_serial        serial line to the pad, idle high, driven from a flop
//   tx_busy          frame in progress or bytes queued
//   fifo_level       queued entries, 0..FIFO_DEPTH
//
// Shifter states:
//   state     | meaning
//   TX_IDLE   | line high, waiting for a queued byte
//   TX_START  | start bit (low) for one bit period
//   TX_DATA   | data bits, LSB first
//   TX_PARITY | parity bit, only when parity was enabled for the frame
//   TX_STOP   | one or two stop bits (high)
module acia_tx_cfg
  import acia_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  acia_tx_cfg_if.slave     wr,
  output logic             tx_serial,
  output logic             tx_busy,
  output logic [AW:0]      fifo_level
);

  tx_state_t        state, state_n;
  logic [DIV_W-1:0] timer, timer_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [2:0]       dlast_q, dlast_n;
  logic [7:0]       shreg, shreg_n;
  logic             par_q, par_n;
  logic             pen_q, pen_n;
  logic             stop2_q, stop2_n;
  logic             tx_serial_n;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] head;
  logic       pop;
  logic       start_frame;
  logic       bit_end;

  acia_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr.tx_valid && wr.tx_ready),
    .wdata   (wr.tx_dat),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign wr.tx_ready = !fifo_full;
  assign tx_busy     = (state != TX_IDLE) || !fifo_empty;
  assign bit_end     = (timer == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= TX_IDLE;
      timer     <= '0;
      div_q     <= '0;
      bit_cnt   <= '0;
      dlast_q   <= '0;
      shreg     <= '0;
      par_q     <= 1'b0;
      pen_q     <= 1'b0;
      stop2_q   <= 1'b0;
      tx_serial <= LINE_IDLE;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      div_q     <= div_n;
      bit_cnt   <= bit_cnt_n;
      dlast_q   <= dlast_n;
      shreg     <= shreg_n;
      par_q     <= par_n;
      pen_q     <= pen_n;
      stop2_q   <= stop2_n;
      tx_serial <= tx_serial_n;
    end
  end

  // tx_serial_n is the level of the bit that starts on the coming edge,
  // so the line changes exactly on bit boundaries.
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    div_n       = div_q;
    bit_cnt_n   = bit_cnt;
    dlast_n     = dlast_q;
    shreg_n     = shreg;
    par_n       = par_q;
    pen_n       = pen_q;
    stop2_n     = stop2_q;
    tx_serial_n = tx_serial;
    pop         = 1'b0;
    start_frame = 1'b0;

    if (state != TX_IDLE) begin
      timer_n = bit_end ? div_q : timer - 1'b1;
    end

    case (state)
      TX_IDLE: begin
        tx_serial_n = LINE_IDLE;
        if (!fifo_empty) start_frame = 1'b1;
      end
      TX_START: begin
        if (bit_end) begin
          state_n     = TX_DATA;
          tx_serial_n = shreg[0];
          shreg_n     = shreg >> 1;
          bit_cnt_n   = dlast_q;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_cnt != '0) begin
            bit_cnt_n   = bit_cnt - 1'b1;
            tx_serial_n = shreg[0];
            shreg_n     = shreg >> 1;
          end else if (pen_q) begin
            state_n     = TX_PARITY;
            tx_serial_n = par_q;
          end else begin
            state_n     = TX_STOP;
            tx_serial_n = 1'b1;
            bit_cnt_n   = {2'b00, stop2_q};
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          state_n     = TX_STOP;
          tx_serial_n = 1'b1;
          bit_cnt_n   = {2'b00, stop2_q};
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (bit_cnt != '0) begin
            bit_cnt_n = bit_cnt - 1'b1;
          end else if (!fifo_empty) begin
            // Next start bit begins on this edge: no idle gap.
            start_frame = 1'b1;
          end else begin
            state_n     = TX_IDLE;
            tx_serial_n = LINE_IDLE;
          end
        end
      end
      default: begin
        state_n     = TX_IDLE;
        tx_serial_n = LINE_IDLE;
      end
    endcase

    // Frame setup snapshots the config so later changes wait for the next frame.
    if (start_frame) begin
      pop         = 1'b1;
      state_n     = TX_START;
      tx_serial_n = 1'b0;
      timer_n     = div;
      div_n       = div;
      shreg_n     = head;
      dlast_n     = {1'b0, data_bits} + 3'd4;
      par_n       = (^(head & data_mask(data_bits))) ^ parity_odd;
      pen_n       = parity_en;
      stop2_n     = stop2;
    end
  end

endmodule

// File: tb/tb_acia_tx_cfg.sv
// tb_acia_tx_cfg: directed bench for acia_tx_cfg. Line samples are recorded
// on every falling edge and compared against hand-computed frame patterns.
module tb_acia_tx_cfg;
  import acia_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] div;
  logic [1:0]  data_bits;
  logic        parity_en, parity_odd, stop2;
  logic        tx_serial, tx_busy;
  logic [2:0]  fifo_level;

  acia_tx_cfg_if wr_if();

  acia_tx_cfg #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .div        (div),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .wr         (wr_if),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  logic rec [0:8191];
  int   cyc = 0;
  always @(negedge clk) begin
    rec[cyc[12:0]] <= tx_serial;
    cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Queue one byte; returns with the index of the first line sample taken
  // after the accepting edge, positioned on the falling edge after it.
  task automatic push(input logic [7:0] b, output int base);
    int n;
    n = 0;
    wr_if.tx_dat   = b;
    wr_if.tx_valid = 1'b1;
    while (!wr_if.tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(32'(n >= 1000), 0, "wr_wait");
    @(posedge clk);
    base = cyc;
    @(negedge clk);
    wr_if.tx_valid = 1'b0;
  endtask

  // bits[k] is the k-th bit period's expected level, each lasting len clocks.
  task automatic check_rec(input int base, input logic [15:0] bits, input int nbits,
                           input int len, input string tag);
    int err;
    err = 0;
    for (int k = 0; k < nbits; k++)
      for (int s = 0; s < len; s++)
        if (rec[base + k*len + s] !== bits[k]) err++;
    chk(err, 0, tag);
  endtask

  logic [7:0] bb [6] = '{8'h11, 8'h22, 8'h3c, 8'ha5, 8'h0f, 8'hf0};

  initial begin
    int b0, b1, act;
    reset_n = 1'b0;
    wr_if.tx_valid = 1'b0;
    wr_if.tx_dat   = 8'h00;
    div = 16'd3; data_bits = DB8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk(tx_serial, 1, "rst_serial");
    chk(wr_if.tx_ready, 1, "rst_ready");
    chk(tx_busy, 0, "rst_busy");
    chk(fifo_level, 0, "rst_level");
    reset_n = 1'b1;
    @(negedge clk);

    // 8N1, div=3, 0x55
    push(8'h55, b0);
    chk(fifo_level, 1, "8n1_level_after_e");
    chk(tx_busy, 1, "8n1_busy_rise");
    chk(tx_serial, 1, "8n1_idle_before_start");
    @(negedge clk);
    chk(fifo_level, 0, "8n1_level_after_pop");
    chk(tx_serial, 0, "8n1_start_latency");
    repeat (39) @(negedge clk);
    chk(tx_busy, 1, "8n1_busy_e40");
    @(negedge clk);
    chk(tx_busy, 0, "8n1_busy_e41");
    @(negedge clk);
    check_rec(b0 + 1, 16'h02aa, 10, 4, "8n1_frame");
    chk(rec[b0 + 41], 1, "8n1_idle_after");

    // 7E2, div=1, 0xC3
    div = 16'd1; data_bits = DB7; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
    push(8'hc3, b0);
    repeat (22) @(negedge clk);
    chk(tx_busy, 1, "7e2_busy_e22");
    @(negedge clk);
    chk(tx_busy, 0, "7e2_busy_e23");
    @(negedge clk);
    check_rec(b0 + 1, 16'h0786, 11, 2, "7e2_frame");

    // 5O1, div=0, 0xFF
    div = 16'd0; data_bits = DB5; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b0;
    push(8'hff, b0);
    repeat (8) @(negedge clk);
    chk(tx_busy, 1, "5o1_busy_e8");
    @(negedge clk);
    chk(tx_busy, 0, "5o1_busy_e9");
    @(negedge clk);
    check_rec(b0 + 1, 16'h00be, 8, 1, "5o1_frame");

    // Burst of six bytes into a 4-deep FIFO, 8N1, div=7
    div = 16'd7; data_bits = DB8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    push(bb[0], b0);
    push(bb[1], b1);
    chk(fifo_level, 1, "burst_level_pushpop");
    push(bb[2], b1);
    push(bb[3], b1);
    chk(wr_if.tx_ready, 1, "burst_ready_at3");
    push(bb[4], b1);
    chk(fifo_level, 4, "burst_level_full");
    chk(wr_if.tx_ready, 0, "burst_ready_full");
    push(bb[5], b1);
    chk(b1 - b0, 82, "burst_accept5_edge");
    chk(fifo_level, 4, "burst_level_refill");
    repeat (400) @(negedge clk);
    chk(tx_busy, 0, "burst_busy_end");
    chk(fifo_level, 0, "burst_level_end");
    for (int j = 0; j < 6; j++)
      check_rec(b0 + 1 + j*80, {6'b0, 1'b1, bb[j], 1'b0}, 10, 8, $sformatf("burst_frame%0d", j));
    chk(rec[b0 + 481], 1, "burst_idle_after");

    // Config change mid-frame: div 3 -> 9 during frame 1 data bits
    div = 16'd3;
    push(8'h0f, b0);
    push(8'ha3, b1);
    repeat (10) @(negedge clk);
    div = 16'd9;
    repeat (135) @(negedge clk);
    chk(tx_busy, 0, "cfg_busy_end");
    check_rec(b0 + 1, {6'b0, 1'b1, 8'h0f, 1'b0}, 10, 4, "cfg_frame1");
    check_rec(b0 + 41, {6'b0, 1'b1, 8'ha3, 1'b0}, 10, 10, "cfg_frame2");

    // Reset during the parity bit with two bytes queued, 8E1, div=3
    div = 16'd3; data_bits = DB8; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b0;
    push(8'h03, b0);
    push(8'h80, b1);
    push(8'h7e, b1);
    chk(fifo_level, 2, "rst_mid_level_before");
    repeat (36) @(negedge clk);
    chk(tx_serial, 0, "rst_mid_parity_bit");
    reset_n = 1'b0;
    #1;
    chk(tx_serial, 1, "rst_mid_serial");
    chk(fifo_level, 0, "rst_mid_level");
    chk(wr_if.tx_ready, 1, "rst_mid_ready");
    chk(tx_busy, 0, "rst_mid_busy");
    @(negedge clk);
    reset_n = 1'b1;
    act = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) act++;
    end
    chk(act, 0, "rst_mid_quiet");

    // 5N1, div=0, upper bits of 0xF5 must be ignored
    div = 16'd0; data_bits = DB5; parity_en = 1'b0; stop2 = 1'b0;
    push(8'hf5, b0);
    repeat (9) @(negedge clk);
    chk(tx_busy, 0, "5n1_busy_end");
    check_rec(b0 + 1, 16'h006a, 7, 1, "5n1_frame");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
